// File: rtl/rf_scoreboard_if.sv
// Register-file scoreboard bundle: decode issue, pipeline/long-unit writeback, RF write port, status.
// Latency: none of its own; pure wiring between the pipeline and the scoreboard.
// Backpressure: iss_stall holds decode; lu_ack releases the long-latency unit's held request.
interface rf_scoreboard_if;
  // Decode-stage issue request
  logic        iss_valid;
  logic [4:0]  iss_rs;
  logic [4:0]  iss_rt;
  logic        iss_use_rs;
  logic        iss_use_rt;
  logic        iss_wr;
  logic [4:0]  iss_rd;
  logic        iss_stall;

  // Pipeline writeback request (always wins the write port)
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  // Long-latency unit writeback request, held until acknowledged
  logic        lu_req;
  logic [4:0]  lu_rd;
  logic [31:0] lu_data;
  logic        lu_ack;

  // Single register-file write port
  logic        WrEn;
  logic [4:0]  Rw;
  logic [31:0] busW;

  // Scoreboard status
  logic [31:0] busy;
  logic [5:0]  pend_cnt;
  logic        err;

  // Pipeline side: drives requests, observes stall/ack/write port/status
  modport master (
    output iss_valid, iss_rs, iss_rt, iss_use_rs, iss_use_rt, iss_wr, iss_rd,
    output wb_valid, wb_rd, wb_data,
    output lu_req, lu_rd, lu_data,
    input  iss_stall, lu_ack,
    input  WrEn, Rw, busW,
    input  busy, pend_cnt, err
  );

  // Scoreboard side
  modport slave (
    input  iss_valid, iss_rs, iss_rt, iss_use_rs, iss_use_rt, iss_wr, iss_rd,
    input  wb_valid, wb_rd, wb_data,
    input  lu_req, lu_rd, lu_data,
    output iss_stall, lu_ack,
    output WrEn, Rw, busW,
    output busy, pend_cnt, err
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Register scoreboard: tracks pending writes, stalls RAW/WAW hazards, arbitrates the single RF write port.
// Latency: stall, write-port mux and lu_ack are combinational; busy/pend_cnt/err update at the next edge.
// Backpressure: iss_stall holds decode on hazard or long-unit drain; lu_req is held until lu_ack.
module rf_scoreboard #(
  parameter int PIPE_DEPTH = 3
) (
  input logic            Clk,
  input logic            Rst_n,
  rf_scoreboard_if.slave sb
);

  // PIPE_DEPTH bounds how long a draining long-unit request can wait; it must describe a real pipeline.
  if (PIPE_DEPTH < 1) begin : g_depth_check
    $error("rf_scoreboard: PIPE_DEPTH must be at least 1");
  end

  // Register state
  logic [31:0] busy_q;
  logic [5:0]  pend_q;
  logic [1:0]  lu_wait_q;
  logic        err_q;

  // Next-state values
  logic [31:0] busy_d;
  logic [5:0]  pend_d;
  logic [1:0]  lu_wait_d;
  logic        err_d;

  // Write-port arbitration
  logic        wb_win;
  logic        lu_win;
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;

  // Issue hazard detection
  logic        rs_hit;
  logic        rt_hit;
  logic        waw_hit;
  logic        drain;
  logic        stall;
  logic        accept;

  // Busy update vectors
  logic [31:0] set_vec;
  logic [31:0] clr_vec;
  logic        orphan_wr;
  logic        collide;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) begin
      n = n + {5'd0, v[i]};
    end
    return n;
  endfunction

  // Fixed-priority write port: pipeline writeback first, long unit only when the pipeline is silent.
  always_comb begin
    wb_win  = sb.wb_valid;
    lu_win  = sb.lu_req && !sb.wb_valid;
    wr_en   = wb_win || lu_win;
    wr_rd   = 5'd0;
    wr_data = 32'd0;
    if (wb_win) begin
      wr_rd   = sb.wb_rd;
      wr_data = sb.wb_data;
    end else if (lu_win) begin
      wr_rd   = sb.lu_rd;
      wr_data = sb.lu_data;
    end
  end

  // Hazard check: RAW on used sources, WAW on the destination, or the long unit starving.
  // busy_q[0] is never set, so register 0 cannot produce a hazard.
  always_comb begin
    rs_hit  = sb.iss_use_rs && busy_q[sb.iss_rs];
    rt_hit  = sb.iss_use_rt && busy_q[sb.iss_rt];
    waw_hit = sb.iss_wr && busy_q[sb.iss_rd];
    // Two cycles of lost arbitration: stop issuing so the pipeline empties and the long unit gets the port.
    drain   = (lu_wait_q >= 2'd2);
    stall   = sb.iss_valid && (rs_hit || rt_hit || waw_hit || drain);
    accept  = sb.iss_valid && !stall;
  end

  // Busy bookkeeping: accepted writers set, RF writes clear (clear wins); writes to r0 touch nothing.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (accept && sb.iss_wr && (sb.iss_rd != 5'd0)) begin
      set_vec[sb.iss_rd] = 1'b1;
    end
    if (wr_en && (wr_rd != 5'd0)) begin
      clr_vec[wr_rd] = 1'b1;
    end
    busy_d    = (busy_q | set_vec) & ~clr_vec;
    busy_d[0] = 1'b0;
    pend_d    = popcount32(busy_d);

    // A write to a register nobody is waiting on, or a same-cycle set/clear, is a protocol error.
    orphan_wr = wr_en && (wr_rd != 5'd0) && !busy_q[wr_rd];
    collide   = |(set_vec & clr_vec);
    err_d     = err_q || orphan_wr || collide;
  end

  // Long-unit starvation counter: counts lost arbitration cycles, saturating at 3.
  always_comb begin
    lu_wait_d = 2'd0;
    if (sb.lu_req && !lu_win) begin
      lu_wait_d = (lu_wait_q == 2'd3) ? 2'd3 : (lu_wait_q + 2'd1);
    end
  end

  // State registers; reset drops every pending write and the sticky error.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      busy_q    <= '0;
      pend_q    <= '0;
      lu_wait_q <= '0;
      err_q     <= 1'b0;
    end else begin
      busy_q    <= busy_d;
      pend_q    <= pend_d;
      lu_wait_q <= lu_wait_d;
      err_q     <= err_d;
    end
  end

  assign sb.iss_stall = stall;
  assign sb.lu_ack    = lu_win;
  assign sb.WrEn      = wr_en;
  assign sb.Rw        = wr_rd;
  assign sb.busW      = wr_data;
  assign sb.busy      = busy_q;
  assign sb.pend_cnt  = pend_q;
  assign sb.err       = err_q;

endmodule

// File: tb/tb_rf_scoreboard.sv
// Testbench for rf_scoreboard: directed scenarios then randomized traffic against a reference model.
// Latency: inputs driven at the falling edge, outputs compared 1ns later, model advanced at the rising edge.
// Backpressure: the traffic generator honours iss_stall and holds long-unit requests until lu_ack.
module tb_rf_scoreboard;
  localparam int PIPE_DEPTH = 3;

  logic Clk;
  logic Rst_n;

  int checks   = 0;
  int failures = 0;

  rf_scoreboard_if bus ();

  rf_scoreboard #(.PIPE_DEPTH(PIPE_DEPTH)) dut (
    .Clk  (Clk),
    .Rst_n(Rst_n),
    .sb   (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Reference model: which registers await a write, sticky error, cycles the long unit has waited.
  bit [31:0] m_busy;
  bit        m_err;
  int        m_wait;
  bit        acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    bus.iss_valid  = 1'b0;
    bus.iss_rs     = 5'd0;
    bus.iss_rt     = 5'd0;
    bus.iss_use_rs = 1'b0;
    bus.iss_use_rt = 1'b0;
    bus.iss_wr     = 1'b0;
    bus.iss_rd     = 5'd0;
    bus.wb_valid   = 1'b0;
    bus.wb_rd      = 5'd0;
    bus.wb_data    = 32'd0;
    bus.lu_req     = 1'b0;
    bus.lu_rd      = 5'd0;
    bus.lu_data    = 32'd0;
  endtask

  task automatic iss(input logic [4:0] rs, input bit urs, input logic [4:0] rt, input bit urt,
                     input bit wr, input logic [4:0] rd);
    bus.iss_valid  = 1'b1;
    bus.iss_rs     = rs;
    bus.iss_use_rs = urs;
    bus.iss_rt     = rt;
    bus.iss_use_rt = urt;
    bus.iss_wr     = wr;
    bus.iss_rd     = rd;
  endtask

  task automatic model_reset();
    m_busy = '0;
    m_err  = 1'b0;
    m_wait = 0;
  endtask

  // A source or destination that is still awaited blocks issue; r0 is never awaited.
  function automatic bit exp_stall();
    bit hazard;
    hazard = (bus.iss_use_rs && bus.iss_rs != 0 && m_busy[bus.iss_rs]) ||
             (bus.iss_use_rt && bus.iss_rt != 0 && m_busy[bus.iss_rt]) ||
             (bus.iss_wr     && bus.iss_rd != 0 && m_busy[bus.iss_rd]);
    return bus.iss_valid && (hazard || m_wait >= 2);
  endfunction

  task automatic check_all();
    bit          ew;
    logic [4:0]  er;
    logic [31:0] ed;
    ew = 1'b0; er = 5'd0; ed = 32'd0;
    if (bus.wb_valid) begin
      ew = 1'b1; er = bus.wb_rd; ed = bus.wb_data;
    end else if (bus.lu_req) begin
      ew = 1'b1; er = bus.lu_rd; ed = bus.lu_data;
    end
    check("iss_stall", bus.iss_stall, exp_stall());
    check("WrEn",      bus.WrEn,      ew);
    check("Rw",        bus.Rw,        er);
    check("busW",      bus.busW,      ed);
    check("lu_ack",    bus.lu_ack,    bus.lu_req && !bus.wb_valid);
    check("busy",      bus.busy,      m_busy);
    check("pend_cnt",  bus.pend_cnt,  32'($countones(m_busy)));
    check("err",       bus.err,       m_err);
  endtask

  task automatic model_update(input bit st);
    bit         ew;
    logic [4:0] er;
    bit         take;
    ew   = bus.wb_valid || bus.lu_req;
    er   = bus.wb_valid ? bus.wb_rd : (bus.lu_req ? bus.lu_rd : 5'd0);
    take = bus.iss_valid && !st;
    if (ew && er != 0 && !m_busy[er]) m_err = 1'b1;
    if (take && bus.iss_wr && bus.iss_rd != 0) begin
      if (ew && er == bus.iss_rd) m_err = 1'b1;
      else m_busy[bus.iss_rd] = 1'b1;
    end
    if (ew && er != 0) m_busy[er] = 1'b0;
    // The long unit waits whenever it asks and the pipeline holds the port.
    if (bus.lu_req && bus.wb_valid) m_wait = (m_wait < 3) ? m_wait + 1 : 3;
    else m_wait = 0;
  endtask

  // One clock: compare everything, advance the model on the edge, return at the next falling edge.
  task automatic step(output bit accepted);
    bit st;
    #1;
    check_all();
    st = exp_stall();
    accepted = bus.iss_valid && !st;
    @(posedge Clk);
    model_update(st);
    @(negedge Clk);
  endtask

  logic [4:0]  pq[$];
  logic [4:0]  luq[$];
  bit          lu_act;
  logic [4:0]  lu_rd_h;
  logic [31:0] lu_dat_h;
  int          pick;

  initial begin
    idle();
    model_reset();
    Rst_n = 1'b0;
    repeat (2) @(negedge Clk);
    #1;
    check("rst_busy", bus.busy, 32'd0);
    check("rst_pend", bus.pend_cnt, 32'd0);
    check("rst_err",  bus.err, 32'd0);
    // Combinational paths stay live while reset is held.
    iss(5'd3, 1'b1, 5'd4, 1'b1, 1'b1, 5'd3);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd4; bus.wb_data = 32'h55;
    #1;
    check("rst_stall", bus.iss_stall, 32'd0);
    check("rst_wren",  bus.WrEn, 32'd1);
    check("rst_rw",    bus.Rw, 32'd4);
    @(negedge Clk);
    idle();
    Rst_n = 1'b1;

    // RAW on rd=10 holds until its writeback edge.
    iss(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd10); step(acc);
    idle(); iss(5'd10, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0);
    #1; check("raw_stall", bus.iss_stall, 32'd1); check("raw_pend1", bus.pend_cnt, 32'd1);
    step(acc);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd10; bus.wb_data = 32'h1234;
    #1; check("raw_stall_wb", bus.iss_stall, 32'd1);
    step(acc);
    bus.wb_valid = 1'b0;
    #1; check("raw_release", bus.iss_stall, 32'd0); check("raw_pend0", bus.pend_cnt, 32'd0);
    step(acc);

    // Simultaneous pipeline and long-unit writes: pipeline first.
    idle(); iss(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd11); step(acc);
    idle(); iss(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd20); step(acc);
    idle();
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd11; bus.wb_data = 32'd15;
    bus.lu_req = 1'b1; bus.lu_rd = 5'd20; bus.lu_data = 32'd128;
    #1;
    check("arb_wren", bus.WrEn, 32'd1); check("arb_rw_wb", bus.Rw, 32'd11);
    check("arb_busw_wb", bus.busW, 32'd15); check("arb_ack0", bus.lu_ack, 32'd0);
    step(acc);
    bus.wb_valid = 1'b0;
    #1;
    check("arb_rw_lu", bus.Rw, 32'd20); check("arb_busw_lu", bus.busW, 32'd128);
    check("arb_ack1", bus.lu_ack, 32'd1);
    step(acc);

    // Register 0: no busy, no stall, no error, but the write still goes out.
    idle(); iss(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = 32'hDEAD;
    #1; check("r0_stall", bus.iss_stall, 32'd0); check("r0_wren", bus.WrEn, 32'd1);
    step(acc);
    idle();
    #1; check("r0_busy", bus.busy, 32'd0); check("r0_err", bus.err, 32'd0);

    // WAW on rd=7: held until the cycle after the rd=7 write.
    iss(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7); step(acc);
    #1; check("waw_stall", bus.iss_stall, 32'd1);
    step(acc);
    #1; check("waw_busy_same", bus.busy, 32'h80);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd7; bus.wb_data = 32'h77;
    #1; check("waw_stall_wb", bus.iss_stall, 32'd1);
    step(acc);
    bus.wb_valid = 1'b0;
    #1; check("waw_accept", bus.iss_stall, 32'd0);
    step(acc);
    idle();
    #1; check("waw_busy_reset", bus.busy, 32'h80);
    bus.wb_valid = 1'b1; bus.wb_rd = 5'd7; step(acc);

    // Long unit starved by three pipeline writes triggers drain.
    idle(); iss(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd21); step(acc);
    for (int r = 1; r <= 3; r++) begin
      idle(); iss(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'(r)); step(acc);
    end
    for (int k = 1; k <= 3; k++) begin
      idle(); iss(5'd9, 1'b0, 5'd9, 1'b0, 1'b0, 5'd0);
      bus.lu_req = 1'b1; bus.lu_rd = 5'd21; bus.lu_data = 32'hABC;
      bus.wb_valid = 1'b1; bus.wb_rd = 5'(k); bus.wb_data = 32'(k);
      #1; check($sformatf("drain_stall_%0d", k), bus.iss_stall, (k == 3) ? 32'd1 : 32'd0);
      step(acc);
    end
    bus.wb_valid = 1'b0;
    #1; check("drain_ack", bus.lu_ack, 32'd1); check("drain_hold", bus.iss_stall, 32'd1);
    step(acc);
    bus.lu_req = 1'b0;
    #1; check("drain_done", bus.iss_stall, 32'd0);
    step(acc);

    // Orphan write sets sticky err; mid-cycle reset clears it immediately.
    idle(); iss(5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9); step(acc);
    idle(); bus.wb_valid = 1'b1; bus.wb_rd = 5'd5; bus.wb_data = 32'h5; step(acc);
    idle();
    #1; check("err_set", bus.err, 32'd1);
    step(acc);
    #1; check("err_sticky", bus.err, 32'd1);
    #2;
    Rst_n = 1'b0;
    model_reset();
    #1;
    check("arst_err", bus.err, 32'd0);
    check("arst_busy", bus.busy, 32'd0);
    check("arst_pend", bus.pend_cnt, 32'd0);
    @(negedge Clk);
    Rst_n = 1'b1;

    // Randomized traffic obeying the handshake rules.
    lu_act = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      idle();
      pick = -1;
      if (pq.size() > 0 && $urandom_range(0, 2) != 0) begin
        pick = int'($urandom_range(0, pq.size() - 1));
        bus.wb_valid = 1'b1; bus.wb_rd = pq[pick]; bus.wb_data = $urandom;
      end else if ($urandom_range(0, 15) == 0) begin
        bus.wb_valid = 1'b1; bus.wb_rd = 5'd0; bus.wb_data = $urandom;
      end
      if (!lu_act && luq.size() > 0 && $urandom_range(0, 1) == 1) begin
        lu_act = 1'b1; lu_rd_h = luq.pop_front(); lu_dat_h = $urandom;
      end
      if (lu_act) begin
        bus.lu_req = 1'b1; bus.lu_rd = lu_rd_h; bus.lu_data = lu_dat_h;
      end
      bus.iss_valid  = ($urandom_range(0, 3) != 0);
      bus.iss_rs     = 5'($urandom_range(0, 7));
      bus.iss_rt     = 5'($urandom_range(0, 7));
      bus.iss_rd     = 5'($urandom_range(0, 7));
      bus.iss_use_rs = ($urandom_range(0, 1) == 1);
      bus.iss_use_rt = ($urandom_range(0, 1) == 1);
      bus.iss_wr     = ($urandom_range(0, 2) != 0);
      step(acc);
      if (pick >= 0) pq.delete(pick);
      if (lu_act && !bus.wb_valid) lu_act = 1'b0;
      if (acc && bus.iss_wr && bus.iss_rd != 0) begin
        if ($urandom_range(0, 3) == 0) luq.push_back(bus.iss_rd);
        else pq.push_back(bus.iss_rd);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rf_scoreboard.md
RF_SCOREBOARD -- requirements
Module: rf_scoreboard

Interface
REQ-001 SHALL have parameter PIPE_DEPTH, default 3, meaning the maximum cycles from issue to pipeline writeback.
REQ-002 SHALL have port Clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port Rst_n  in  1  asynchronous active-low reset.
REQ-004 SHALL have port iss_valid  in  1  decode stage presents an instruction.
REQ-005 SHALL have ports iss_rs, iss_rt  in  5 each  source register numbers.
REQ-006 SHALL have ports iss_use_rs, iss_use_rt  in  1 each  source actually read.
REQ-007 SHALL have ports iss_wr  in  1  and iss_rd  in  5  instruction writes register iss_rd.
REQ-008 SHALL have port iss_stall  out  1  decode holds; instruction not accepted.
REQ-009 SHALL have ports wb_valid  in  1,  wb_rd  in  5,  wb_data  in  32  for the pipeline writeback request.
REQ-010 SHALL have ports lu_req  in  1,  lu_rd  in  5,  lu_data  in  32  for the long-latency unit (mul/div) writeback request.
REQ-011 SHALL have port lu_ack  out  1  long-unit write performed this cycle.
REQ-012 SHALL have ports WrEn  out  1,  Rw  out  5,  busW  out  32  driving the single register-file write port.
REQ-013 SHALL have port busy  out  32  per-register pending-write vector.
REQ-014 SHALL have port pend_cnt  out  6  number of set busy bits.
REQ-015 SHALL have port err  out  1  sticky protocol-error flag.

Function
REQ-016 Issue accepted = iss_valid && !iss_stall; accepted with iss_wr && iss_rd!=0 SHALL set busy[iss_rd] at the next edge.
REQ-017 iss_stall SHALL be combinational: iss_valid && (RAW || WAW || drain), where RAW = (iss_use_rs && busy[iss_rs]) || (iss_use_rt && busy[iss_rt]), WAW = iss_wr && busy[iss_rd].
REQ-018 busy[0] SHALL always be 0; register 0 never causes a stall or sets busy.
REQ-019 Write-port arbitration SHALL be fixed priority: wb_valid wins; lu_req is granted only when wb_valid=0.
REQ-020 On grant, WrEn=1, Rw and busW SHALL come combinationally from the winner; with no request, WrEn=0, Rw=0, busW=0.
REQ-021 lu_ack SHALL equal lu_req && !wb_valid; the long unit holds lu_rd/lu_data stable until lu_ack.
REQ-022 A write to Rw!=0 SHALL clear busy[Rw] at the same edge the register file captures the data.
REQ-023 A write to Rw=0 SHALL be accepted but change no state.
REQ-024 A 2-bit saturating counter lu_wait SHALL increment each cycle with lu_req && !lu_ack, saturate at 3, and clear on lu_ack or !lu_req.
REQ-025 drain SHALL be lu_wait>=2; it blocks new issues so the pipeline empties and lu_req is granted within PIPE_DEPTH further cycles.
REQ-026 Set and clear of the same register in one cycle cannot occur (WAW stall); if it does, clear SHALL win and err SHALL set.
REQ-027 err SHALL set on any write (wb or lu) to Rw!=0 whose busy bit is 0, and stay set until reset.
REQ-028 pend_cnt SHALL equal popcount(busy) registered, updated at the same edge as busy (range 0..31).

Reset
REQ-029 Rst_n=0 SHALL asynchronously clear busy, pend_cnt, lu_wait and err regardless of Clk.
REQ-030 During reset, iss_stall, WrEn and lu_ack SHALL still follow their combinational equations using the cleared state.
REQ-031 Reset during an outstanding operation SHALL discard all pending state; the requesters must be reset by the same Rst_n.

Verification
REQ-032 Issue rd=10 (iss_wr=1), then next cycle issue with rs=10, use_rs=1 -> iss_stall=1 until wb_valid,wb_rd=10 edge, then 0; pend_cnt 1->0.
REQ-033 wb_valid(rd=11,data=15) and lu_req(rd=20,data=128) together -> WrEn=1,Rw=11,busW=15,lu_ack=0; next cycle wb_valid=0 -> Rw=20,busW=128,lu_ack=1.
REQ-034 lu_req held with wb_valid=1 for 3 cycles -> lu_wait 1,2,3; iss_stall=1 from the 3rd cycle on any iss_valid; lu_ack once wb_valid drops; lu_wait=0 next.
REQ-035 Issue rd=0 and write Rw=0 -> busy stays 0, no stall, err=0, WrEn=1.
REQ-036 wb_valid with wb_rd=5 while busy[5]=0 -> err=1 and remains 1; Rst_n pulsed low mid-cycle -> err, busy, pend_cnt immediately 0.
REQ-037 Issue rd=7 while busy[7]=1 -> WAW stall; no busy change; accepted the cycle after the rd=7 write.
